// File: rtl/usb_crc5_check.sv
// usb_crc5_check: receive-side USB token CRC5 checker with address/endpoint capture.
// Verdict (crc_done/crc_ok/crc_err) is registered and appears 1 cycle after eop is sampled.
// No backpressure: one bit absorbed per shift_enable cycle, shift_enable may be high every cycle.
//
// Ports:
//   clk, n_rst           clock, asynchronous active-low reset
//   start                (re)arms the checker with a fresh LFSR seed
//   shift_enable, d_orig one decoded, unstuffed bit per qualified cycle
//   eop                  end-of-packet pulse
//   busy                 high from start until the verdict pulse ends
//   crc_done/ok/err      one-cycle verdict strobe and result
//   token_addr/endp      captured payload fields, held until the next start
//   err_count            saturating error count; built only when USB_CRC5_ERRCNT_EN
//                        is defined, otherwise tied to zero
module usb_crc5_check #(
  parameter logic [4:0] RESIDUE = 5'b01100,
  parameter logic [4:0] INIT    = 5'b11111
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       shift_enable,
  input  logic       d_orig,
  input  logic       eop,
  output logic       busy,
  output logic       crc_done,
  output logic       crc_ok,
  output logic       crc_err,
  output logic [6:0] token_addr,
  output logic [3:0] token_endp,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CRC,
    S_WAIT_EOP,
    S_VERDICT
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  lfsr_q, lfsr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        long_q, long_d;
  logic [10:0] tok_q, tok_d;
  logic        busy_q, busy_d;
  logic        crc_done_q, crc_done_d;
  logic        crc_ok_q, crc_ok_d;
  logic        crc_err_q, crc_err_d;

  // Absorb-then-evaluate: eop in the same cycle as a bit sees the updated count/LFSR.
  logic        in_pkt;
  logic        absorb;
  logic        fb;
  logic [4:0]  lfsr_step;
  logic [4:0]  lfsr_upd;
  logic [4:0]  cnt_upd;
  logic        long_upd;

  assign in_pkt    = (state_q == S_PAYLOAD) || (state_q == S_CRC) || (state_q == S_WAIT_EOP);
  assign absorb    = shift_enable && !start && ((state_q == S_PAYLOAD) || (state_q == S_CRC));
  assign fb        = lfsr_q[4] ^ d_orig;
  assign lfsr_step = {lfsr_q[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
  assign lfsr_upd  = absorb ? lfsr_step : lfsr_q;
  assign cnt_upd   = absorb ? (cnt_q + 5'd1) : cnt_q;
  // Bits arriving after the CRC mark the packet as too long; the LFSR stays frozen.
  assign long_upd  = long_q || (shift_enable && (state_q == S_WAIT_EOP));

  // State register and all datapath flops
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= INIT;
      cnt_q      <= 5'd0;
      long_q     <= 1'b0;
      tok_q      <= 11'd0;
      busy_q     <= 1'b0;
      crc_done_q <= 1'b0;
      crc_ok_q   <= 1'b0;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      long_q     <= long_d;
      tok_q      <= tok_d;
      busy_q     <= busy_d;
      crc_done_q <= crc_done_d;
      crc_ok_q   <= crc_ok_d;
      crc_err_q  <= crc_err_d;
    end
  end

  // Next-state logic; start overrides everything, including a same-cycle eop
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_PAYLOAD;
    end else begin
      case (state_q)
        S_IDLE:     state_d = S_IDLE;
        S_PAYLOAD:  if (eop) state_d = S_VERDICT;
                    else if (cnt_upd == 5'd11) state_d = S_CRC;
        S_CRC:      if (eop) state_d = S_VERDICT;
                    else if (cnt_upd == 5'd16) state_d = S_WAIT_EOP;
        S_WAIT_EOP: if (eop) state_d = S_VERDICT;
        S_VERDICT:  state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    lfsr_d     = lfsr_upd;
    cnt_d      = cnt_upd;
    long_d     = long_upd;
    tok_d      = tok_q;
    busy_d     = (state_d != S_IDLE);
    crc_done_d = in_pkt && !start && eop;
    // A pass needs exactly 16 bits, no trailing bits and the matching residue.
    crc_ok_d   = crc_done_d && (cnt_upd == 5'd16) && !long_upd && (lfsr_upd == RESIDUE);
    crc_err_d  = crc_done_d && !crc_ok_d;

    if (absorb && (state_q == S_PAYLOAD)) begin
      for (int i = 0; i < 11; i++) begin
        if (cnt_q == 5'(i)) tok_d[i] = d_orig;
      end
    end

    if (start) begin
      lfsr_d = INIT;
      cnt_d  = 5'd0;
      long_d = 1'b0;
    end
  end

  assign busy       = busy_q;
  assign crc_done   = crc_done_q;
  assign crc_ok     = crc_ok_q;
  assign crc_err    = crc_err_q;
  assign token_addr = tok_q[6:0];
  assign token_endp = tok_q[10:7];

`ifdef USB_CRC5_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts alongside the error strobe, so the new value is visible during the pulse.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (crc_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) err_cnt_q <= 8'h00;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_usb_crc5_check.sv
module tb_usb_crc5_check;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic       shift_enable;
  logic       d_orig;
  logic       eop;
  logic       busy;
  logic       crc_done;
  logic       crc_ok;
  logic       crc_err;
  logic [6:0] token_addr;
  logic [3:0] token_endp;
  logic [7:0] err_count;

  usb_crc5_check dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .shift_enable (shift_enable),
    .d_orig       (d_orig),
    .eop          (eop),
    .busy         (busy),
    .crc_done     (crc_done),
    .crc_ok       (crc_ok),
    .crc_err      (crc_err),
    .token_addr   (token_addr),
    .token_endp   (token_endp),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ok;
    logic       chk_tok;
    logic [6:0] addr;
    logic [3:0] endp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_err  = 0;

  // Bits in send order, index 0 first: payload 1,0,1,0,1,0,0,0,1,1,1 then CRC 1,0,1,1,1
  logic [16:0] good_pkt;
  logic [16:0] bad_pkt;
  logic [16:0] long_pkt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ok, input logic chk_tok);
    exp_t e;
    e.ok      = ok;
    e.chk_tok = chk_tok;
    e.addr    = 7'h15;
    e.endp    = 4'hE;
    sb.push_back(e);
`ifdef USB_CRC5_ERRCNT_EN
    if (!ok && exp_err < 255) exp_err++;
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [16:0] bits, input int n, input logic eop_last);
    for (int i = 0; i < n; i++) begin
      shift_enable = 1'b1;
      d_orig       = bits[i];
      eop          = (eop_last && i == n - 1);
      cyc();
    end
    shift_enable = 1'b0;
    d_orig       = 1'b0;
    eop          = 1'b0;
  endtask

  task automatic end_pkt();
    eop = 1'b1;
    cyc();
    eop = 1'b0;
  endtask

  // Monitor: every verdict pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (n_rst && crc_done) begin
      if (sb.size() == 0) begin
        check("unexpected_crc_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("crc_ok", 32'(crc_ok), 32'(e.ok));
        check("crc_err", 32'(crc_err), 32'(!e.ok));
        if (e.chk_tok) begin
          check("token_addr", 32'(token_addr), 32'(e.addr));
          check("token_endp", 32'(token_endp), 32'(e.endp));
        end
      end
    end
  end

  initial begin
    good_pkt     = 17'h0EF15;
    bad_pkt      = 17'h06F15;
    long_pkt     = 17'h1EF15;
    n_rst        = 1'b0;
    start        = 1'b0;
    shift_enable = 1'b0;
    d_orig       = 1'b0;
    eop          = 1'b0;
    cyc();
    cyc();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_crc_done", 32'(crc_done), 32'd0);
    check("rst_crc_ok", 32'(crc_ok), 32'd0);
    check("rst_crc_err", 32'(crc_err), 32'd0);
    check("rst_token_addr", 32'(token_addr), 32'd0);
    check("rst_token_endp", 32'(token_endp), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    n_rst = 1'b1;
    cyc();

    // eop while idle is ignored
    end_pkt();
    cyc();
    check("idle_eop_busy", 32'(busy), 32'd0);

    // Valid packet with verdict timing
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    push(1'b1, 1'b1);
    send_bits(good_pkt, 16, 1'b0);
    check("busy_before_eop", 32'(busy), 32'd1);
    end_pkt();
    check("done_1cyc_after_eop", 32'(crc_done), 32'd1);
    check("busy_in_verdict", 32'(busy), 32'd1);
    cyc();
    check("done_one_cycle", 32'(crc_done), 32'd0);
    check("busy_falls_with_done", 32'(busy), 32'd0);
    check("held_addr", 32'(token_addr), 32'h15);
    check("held_endp", 32'(token_endp), 32'hE);

    // Last CRC bit flipped
    pulse_start();
    push(1'b0, 1'b1);
    send_bits(bad_pkt, 16, 1'b0);
    end_pkt();
    cyc();
    check("err_count_after_bad", 32'(err_count), 32'(exp_err));

    // Short packet: 10 payload bits
    pulse_start();
    push(1'b0, 1'b0);
    send_bits(good_pkt, 10, 1'b0);
    end_pkt();
    check("short_busy_verdict", 32'(busy), 32'd1);
    cyc();
    check("short_busy_low", 32'(busy), 32'd0);

    // Long packet: 17 bits
    pulse_start();
    push(1'b0, 1'b1);
    send_bits(long_pkt, 17, 1'b0);
    end_pkt();
    cyc();

    // Restart after 6 bits, then a full valid packet: one pulse only
    pulse_start();
    send_bits(good_pkt, 6, 1'b0);
    pulse_start();
    push(1'b1, 1'b1);
    send_bits(good_pkt, 16, 1'b0);
    end_pkt();
    cyc();

    // eop together with the final CRC bit
    pulse_start();
    push(1'b1, 1'b1);
    send_bits(good_pkt, 16, 1'b1);
    check("same_cycle_eop_done", 32'(crc_done), 32'd1);
    cyc();

    // Back-to-back start in the verdict cycle
    pulse_start();
    push(1'b1, 1'b1);
    send_bits(good_pkt, 16, 1'b0);
    end_pkt();
    pulse_start();
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done_cleared", 32'(crc_done), 32'd0);
    push(1'b1, 1'b1);
    send_bits(good_pkt, 16, 1'b0);
    end_pkt();
    cyc();

    // 300 bad packets: counter saturates when built
    for (int k = 0; k < 300; k++) begin
      pulse_start();
      push(1'b0, 1'b1);
      send_bits(bad_pkt, 16, 1'b0);
      end_pkt();
      cyc();
    end
    check("err_count_saturated", 32'(err_count), 32'(exp_err));

    // Reset mid-packet: everything clears, no verdict
    pulse_start();
    send_bits(good_pkt, 5, 1'b0);
    n_rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_crc_done", 32'(crc_done), 32'd0);
    check("arst_token_addr", 32'(token_addr), 32'd0);
    check("arst_token_endp", 32'(token_endp), 32'd0);
    check("arst_err_count", 32'(err_count), 32'd0);
    cyc();
    cyc();
    n_rst = 1'b1;
    end_pkt();
    cyc();
    cyc();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_crc5_check.md
# usb_crc5_check

Receive-side CRC5 checker for USB token packets. Sits after the NRZI decoder and bit-unstuffer in the receiver. It runs the USB CRC5 LFSR serially over the 11 payload bits (address, endpoint) and the 5 received CRC bits. On EOP it reports a one-cycle pass/fail verdict together with the captured address and endpoint fields.

## Interface
Parameters:
- RESIDUE, 5'b01100, expected LFSR residue after all 16 bits are absorbed (order c4..c0)
- INIT, 5'b11111, LFSR seed loaded on start

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse after the token PID is accepted; (re)arms the checker
- shift_enable  in  1  qualifies d_orig; one bit absorbed per asserted cycle
- d_orig  in  1  decoded, unstuffed bit, LSB-first payload, then CRC MSB-first
- eop  in  1  end-of-packet detected (one-cycle pulse)
- busy  out  1  high from start until the verdict pulse
- crc_done  out  1  one-cycle verdict strobe
- crc_ok  out  1  valid with crc_done: 16 bits received and residue matched
- crc_err  out  1  valid with crc_done: residue mismatch, short packet or long packet
- token_addr  out  7  payload bits 0-6, held until the next start
- token_endp  out  4  payload bits 7-10, held until the next start
- err_count  out  8  saturating error count (see Configuration)

## Operation
- LFSR step on each shift_enable: fb = lfsr[4] ^ d_orig; lfsr <= {lfsr[3:0],1'b0} ^ (fb ? 5'b00101 : 5'b0). The polynomial is x^5+x^2+1.
- 5-bit bit counter bit_cnt counts the bits absorbed since start.
- FSM states:
  - IDLE: outputs quiet. On start, load lfsr=INIT, bit_cnt=0, go to PAYLOAD.
  - PAYLOAD: each shift_enable shifts d_orig into the addr/endp shift register at index bit_cnt and steps the LFSR. After the 11th bit, go to CRC.
  - CRC: each shift_enable steps the LFSR only. After the 5th bit, go to WAIT_EOP.
  - WAIT_EOP:
    - On eop, go to VERDICT with result = (lfsr == RESIDUE).
    - On any further shift_enable, set the long flag. The LFSR freezes and the block keeps waiting for eop; the verdict is then crc_err.
  - VERDICT: pulse crc_done for one cycle with exactly one of crc_ok or crc_err high. Return to IDLE.
- eop seen in PAYLOAD or CRC (short packet): go to VERDICT with crc_err.
- eop in IDLE is ignored.
- A start in any non-IDLE state restarts from PAYLOAD with a fresh seed. No verdict is issued for the abandoned packet.
- If start and eop arrive in the same cycle, start wins.
- If shift_enable and eop arrive in the same cycle, the bit is absorbed first, then eop is evaluated against the updated count and LFSR.
- token_addr and token_endp update bit-by-bit during PAYLOAD. They are stable from the end of PAYLOAD until the next start.

## Timing
- Reset values: state IDLE; busy, crc_done, crc_ok, crc_err = 0; token_addr = 0; token_endp = 0; err_count = 0; lfsr = INIT.
- Reset asserted mid-packet aborts immediately. No verdict is issued.
- busy rises the cycle after start is sampled.
- crc_done, crc_ok and crc_err are registered. They assert exactly 1 cycle after the eop edge is sampled and last 1 cycle.
- busy falls in the same cycle that crc_done deasserts.
- A back-to-back start is accepted in the VERDICT cycle; it restarts the checker and the verdict pulse is still emitted.
- There is no minimum gap between shift_enable pulses. shift_enable may be high on every cycle.

## Configuration
- USB_CRC5_ERRCNT_EN:
  - Defined: err_count increments by 1 on every crc_done that carries crc_err and saturates at 8'hFF. It is cleared only by reset.
  - Undefined: err_count is tied to 8'h00 and the counter logic is not built.

## Test plan
- Start, then addr 7'h15 / endp 4'hE (LSB-first bits 1,0,1,0,1,0,0,0,1,1,1), then CRC bits 1,0,1,1,1, then eop -> LFSR = 5'b01100; crc_done + crc_ok 1 cycle after eop; token_addr = 7'h15; token_endp = 4'hE.
- Same packet with the last CRC bit flipped to 0 -> crc_done + crc_err; crc_ok = 0; err_count = 1 (macro defined) or 0 (undefined).
- eop after only 10 payload bits -> crc_err, state returns to IDLE, busy low 2 cycles after eop.
- 17 bits (a valid packet plus one extra bit) before eop -> crc_err.
- start reissued after 6 bits, then a full valid packet -> exactly one crc_done pulse, with crc_ok.
- 300 consecutive bad packets with the macro defined -> err_count saturates at 8'hFF. Then n_rst low mid-packet -> all outputs return to 0 with no crc_done pulse.
